// File: rtl/neuron_layer_datapath.sv
// Neuron MAC datapath: dot product + bias, saturate, ReLU, ping-pong activation buffers.
// Optional NEURON_LAST_LAYER_LINEAR_EN bypasses the ReLU on the final weight layer.
module neuron_layer_datapath #(
  parameter int unsigned M    = 3,
  parameter int unsigned N    = 2,
  parameter int unsigned DW   = 8,
  parameter int unsigned FRAC = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         load_in,
  input  logic [N*DW-1:0]              x_in,
  input  logic                         read_en,
  input  logic                         write_en,
  input  logic [$clog2(M-1)-1:0]       layer_addr,
  input  logic [$clog2(N)-1:0]         neuron_addr,
  output logic                         w_rd,
  output logic [$clog2((M-1)*N)-1:0]   w_addr,
  input  logic [N*DW-1:0]              w_row,
  input  logic [DW-1:0]                bias,
  output logic                         busy,
  output logic [N*DW-1:0]              y_out,
  output logic                         y_valid
);
  localparam int unsigned LW   = $clog2(M-1);
  localparam int unsigned NW   = $clog2(N);
  localparam int unsigned AW   = $clog2((M-1)*N);
  localparam int unsigned AccW = 2*DW + $clog2(N+1);
  localparam logic signed [AccW-1:0] SatMax = AccW'((2**(DW-1)) - 1);
  localparam logic signed [AccW-1:0] SatMin = -SatMax - 1;

  logic [N*DW-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d, y_out_q, y_out_d;
  logic            sel_q, sel_d, y_valid_q, y_valid_d;
  logic            s1_valid_q, s1_valid_d, s1_we_q, s1_we_d;
  logic [LW-1:0]   s1_layer_q, s1_layer_d;
  logic [NW-1:0]   s1_neuron_q, s1_neuron_d;

  logic [N*DW-1:0]          x_src;
  logic signed [2*DW-1:0]   prod;
  logic signed [AccW-1:0]   acc, shifted;
  logic [DW-1:0]            res;
  logic                     relu_en, is_final, is_last;

  assign w_rd    = read_en;
  assign w_addr  = AW'(layer_addr) * AW'(N) + AW'(neuron_addr);
  assign busy    = read_en | s1_valid_q;
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

  assign x_src    = sel_q ? buf_b_q : buf_a_q;
  assign is_final = (s1_layer_q == LW'(M-2));
  assign is_last  = (s1_neuron_q == NW'(N-1));

  always_comb begin
    prod = '0;
    acc  = {{(AccW-DW){bias[DW-1]}}, bias};
    acc  = acc <<< FRAC;
    for (int i = 0; i < N; i++) begin
      prod = $signed(x_src[i*DW +: DW]) * $signed(w_row[i*DW +: DW]);
      acc  = acc + {{(AccW-2*DW){prod[2*DW-1]}}, prod};
    end
    shifted = acc >>> FRAC;
    if (shifted > SatMax) begin
      res = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < SatMin) begin
      res = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res = shifted[DW-1:0];
    end
`ifdef NEURON_LAST_LAYER_LINEAR_EN
    relu_en = !is_final;
`else
    relu_en = 1'b1;
`endif
    if (relu_en && res[DW-1]) res = '0;
  end

  always_comb begin
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    y_out_d     = y_out_q;
    sel_d       = sel_q;
    y_valid_d   = 1'b0;
    s1_valid_d  = read_en;
    s1_we_d     = read_en & write_en;
    s1_layer_d  = read_en ? layer_addr : s1_layer_q;
    s1_neuron_d = read_en ? neuron_addr : s1_neuron_q;

    // Loads only happen while idle, so they never collide with a layer write into A.
    if (load_in && !busy) buf_a_d = x_in;

    if (s1_valid_q && s1_we_q) begin
      if (is_final) begin
        y_out_d[int'(s1_neuron_q)*DW +: DW] = res;
        if (is_last) begin
          y_valid_d = 1'b1;
          sel_d     = 1'b0;
        end
      end else begin
        if (sel_q) buf_a_d[int'(s1_neuron_q)*DW +: DW] = res;
        else       buf_b_d[int'(s1_neuron_q)*DW +: DW] = res;
        if (is_last) sel_d = ~sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      buf_a_q     <= '0;
      buf_b_q     <= '0;
      y_out_q     <= '0;
      sel_q       <= 1'b0;
      y_valid_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_layer_q  <= '0;
      s1_neuron_q <= '0;
    end else begin
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      y_out_q     <= y_out_d;
      sel_q       <= sel_d;
      y_valid_q   <= y_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_we_q     <= s1_we_d;
      s1_layer_q  <= s1_layer_d;
      s1_neuron_q <= s1_neuron_d;
    end
  end
endmodule

// File: tb/tb_neuron_layer_datapath.sv
// Directed bench for neuron_layer_datapath (M=3, N=2, DW=8, FRAC=4) with a synchronous weight RAM.
module tb_neuron_layer_datapath;
  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        load_in = 1'b0;
  logic [15:0] x_in = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [0:0]  layer_addr = '0;
  logic [0:0]  neuron_addr = '0;
  logic        w_rd;
  logic [1:0]  w_addr;
  logic [15:0] w_row = '0;
  logic [7:0]  bias = '0;
  logic        busy;
  logic [15:0] y_out;
  logic        y_valid;

  logic [15:0] wmem [4];
  logic [7:0]  bmem [4];
  int vectors = 0;
  int miscompares = 0;

  neuron_layer_datapath dut (
    .clk(clk), .nrst(nrst), .load_in(load_in), .x_in(x_in), .read_en(read_en),
    .write_en(write_en), .layer_addr(layer_addr), .neuron_addr(neuron_addr), .w_rd(w_rd),
    .w_addr(w_addr), .w_row(w_row), .bias(bias), .busy(busy), .y_out(y_out), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd) begin
      w_row <= wmem[w_addr];
      bias  <= bmem[w_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_layer(input int l, input logic [15:0] r0, input logic [15:0] r1,
                           input logic [7:0] b);
    wmem[l*2]   = r0;
    wmem[l*2+1] = r1;
    bmem[l*2]   = b;
    bmem[l*2+1] = b;
  endtask

  // Starts at a negedge with the bench idle; ends on the negedge where y_valid is high.
  task automatic run(input string tag, input logic [15:0] x, input logic [15:0] exp_y);
    chk({tag, "_sel0"}, 32'(dut.sel_q), 32'd0);
    load_in = 1'b1;
    x_in    = x;
    @(negedge clk);
    load_in = 1'b0;
    chk({tag, "_vld_lo"}, 32'(y_valid), 32'd0);
    chk({tag, "_buf_a"}, 32'(dut.buf_a_q), 32'(x));
    for (int l = 0; l < 2; l++) begin
      for (int n = 0; n < 2; n++) begin
        read_en     = 1'b1;
        write_en    = 1'b1;
        layer_addr  = 1'(l);
        neuron_addr = 1'(n);
        @(negedge clk);
      end
    end
    read_en  = 1'b0;
    write_en = 1'b0;
    chk({tag, "_vld_early"}, 32'(y_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(y_valid), 32'd1);
    chk({tag, "_y"}, 32'(y_out), 32'(exp_y));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      wmem[i] = '0;
      bmem[i] = '0;
    end
    #1 nrst = 1'b0;
    #10;
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_vld", 32'(y_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a", 32'(dut.buf_a_q), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Identity through both layers.
    set_layer(0, 16'h0010, 16'h1000, 8'h00);
    set_layer(1, 16'h0010, 16'h1000, 8'h00);
    run("ident", 16'h3020, 16'h3020);
    @(negedge clk);
    chk("ident_vld_off", 32'(y_valid), 32'd0);

    // Hidden ReLU clamps row1 (-1.0) to zero.
    set_layer(0, 16'h1010, 16'hF010, 8'h00);
    run("relu", 16'h2010, 16'h0030);
    chk("relu_h", 32'(dut.buf_b_q), 32'h0030);
    // Back-to-back: final-layer row0 = -1.0.
    set_layer(1, 16'h00F0, 16'h1000, 8'h00);
`ifdef NEURON_LAST_LAYER_LINEAR_EN
    run("lastlin", 16'h2010, 16'h00D0);
`else
    run("lastlin", 16'h2010, 16'h0000);
`endif

    // Positive saturation through both layers.
    set_layer(0, 16'h2020, 16'h2020, 8'h10);
    set_layer(1, 16'h2020, 16'h2020, 8'h10);
    run("satpos", 16'h7070, 16'h7F7F);
    // Final layer saturates negative.
    set_layer(1, 16'hE0E0, 16'hE0E0, 8'h10);
`ifdef NEURON_LAST_LAYER_LINEAR_EN
    run("satneg", 16'h7070, 16'h8080);
`else
    run("satneg", 16'h7070, 16'h0000);
`endif

    // Back-to-back identity runs with fresh inputs.
    set_layer(0, 16'h0010, 16'h1000, 8'h00);
    set_layer(1, 16'h0010, 16'h1000, 8'h00);
    run("b2b_1", 16'h4211, 16'h4211);
    run("b2b_2", 16'h7F05, 16'h7F05);

    // Reads without write_en change nothing.
    @(negedge clk);
    read_en = 1'b1; write_en = 1'b0; layer_addr = 1'b0; neuron_addr = 1'b1;
    @(negedge clk);
    layer_addr = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    chk("nowr_b", 32'(dut.buf_b_q), 32'h7F05);
    chk("nowr_sel", 32'(dut.sel_q), 32'd0);
    chk("nowr_y", 32'(y_out), 32'h7F05);
    chk("nowr_vld", 32'(y_valid), 32'd0);

    // Reset mid layer 1, with a load attempted while busy.
    load_in = 1'b1; x_in = 16'h3020;
    @(negedge clk);
    load_in = 1'b0;
    for (int n = 0; n < 2; n++) begin
      read_en = 1'b1; write_en = 1'b1; layer_addr = 1'b0; neuron_addr = 1'(n);
      @(negedge clk);
    end
    layer_addr = 1'b1; neuron_addr = 1'b0;
    load_in = 1'b1; x_in = 16'hAAAA;
    #1 chk("busy_hi", 32'(busy), 32'd1);
    @(negedge clk);
    load_in = 1'b0;
    chk("busy_load_a", 32'(dut.buf_a_q), 32'h3020);
    chk("mid_b", 32'(dut.buf_b_q), 32'h3020);
    chk("mid_sel", 32'(dut.sel_q), 32'd1);
    neuron_addr = 1'b1;
    #2 nrst = 1'b0;
    #1;
    chk("mrst_a", 32'(dut.buf_a_q), 32'd0);
    chk("mrst_b", 32'(dut.buf_b_q), 32'd0);
    chk("mrst_y", 32'(y_out), 32'd0);
    chk("mrst_sel", 32'(dut.sel_q), 32'd0);
    read_en = 1'b0; write_en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mrst_novld", 32'(y_valid), 32'd0);
    end
    chk("mrst_y_end", 32'(y_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
